fetch_queue: RTL

- Instruction-fetch front end that drives instruction-memory read port 0 and feeds the decode stage.
- Tracks in-flight reads across the fixed memory latency and buffers returned instructions with their PCs in a DEPTH-entry FIFO.
- Presents the FIFO head to decode under a valid/stall handshake.
- Discards all queued and in-flight work on an execute-stage redirect (flush) and restarts fetching at the redirect target.

---
 rtl/fetch_queue.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_queue                                                   |
// | Purpose  : Instruction-fetch front end. Drives instruction-memory read   |
// |            port 0 and tracks reads in flight across the fixed memory     |
// |            latency. Buffers returned instructions with their PCs in a    |
// |            DEPTH-entry FIFO and presents the head to decode under a       |
// |            valid/stall handshake. An execute-stage flush discards all     |
// |            queued and in-flight work and restarts fetch at flush_pc.      |
// | Options  : FETCH_QUEUE_BYPASS_EN - when defined, a return arriving while  |
// |            the FIFO is empty is shown on the outputs in the same cycle.   |
// | Ports    : clk             - clock, rising-edge                          |
// |            rst             - asynchronous active-high reset              |
// |            flush/flush_pc  - redirect request and byte target            |
// |            stall           - decode cannot take the head this cycle      |
// |            mem_raddr       - word address to memory (fetch_pc[15:1])     |
// |            mem_rdata       - instruction returned by memory              |
// |            out_valid/out_pc/out_instruction - presented instruction      |
// |            count           - FIFO occupancy, 0..DEPTH                    |
// | Revision : 1.0 - initial release                                        |
// +--------------------------------------------------------------------------+
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          MEM_LAT  = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [15:0]             flush_pc,
  input  logic                    stall,
  output logic [14:0]             mem_raddr,
  input  logic [15:0]             mem_rdata,
  output logic                    out_valid,
  output logic [15:0]             out_pc,
  output logic [15:0]             out_instruction,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int              C_PW        = $clog2(DEPTH);
  localparam int              C_CW        = C_PW + 1;
  localparam logic [C_PW-1:0] C_PTR_ONE   = C_PW'(1);
  localparam logic [C_CW-1:0] C_CNT_ONE   = C_CW'(1);
  localparam logic [C_CW-1:0] C_CNT_DEPTH = C_CW'(DEPTH);
  localparam logic [7:0]      C_DEPTH8    = 8'(DEPTH);
  localparam logic [15:0]     C_PC_MASK   = 16'hFFFE;

  // Fetch state and issue pipe (stage MEM_LAT-1 lines up with mem_rdata)
  logic [15:0]        r_fetch_pc;
  logic [MEM_LAT-1:0] r_pipe_vld;
  logic [15:0]        r_pipe_pc [MEM_LAT];

  // FIFO
  logic [15:0]        r_fifo_pc    [DEPTH];
  logic [15:0]        r_fifo_instr [DEPTH];
  logic [C_PW-1:0]    r_wr_ptr;
  logic [C_PW-1:0]    r_rd_ptr;
  logic [C_CW-1:0]    r_count;

  logic [7:0]         w_inflight;
  logic [7:0]         w_occ;
  logic               w_issue_ok;
  logic               w_ret_valid;
  logic [15:0]        w_ret_pc;
  logic               w_bypass;
  logic               w_fifo_nonempty;
  logic               w_pop;
  logic               w_fifo_pop;
  logic               w_push;

  assign mem_raddr = r_fetch_pc[15:1];
  assign count     = r_count;

  assign w_ret_valid     = r_pipe_vld[MEM_LAT-1];
  assign w_ret_pc        = r_pipe_pc[MEM_LAT-1];
  assign w_fifo_nonempty = (r_count != '0);

  // Credits: every in-flight read already owns a FIFO slot, so a read is
  // only issued when queued plus in-flight entries leave room. A pop in the
  // same cycle is deliberately not counted, keeping this path short.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      w_inflight = w_inflight + 8'(r_pipe_vld[i]);
    end
  end

  assign w_occ      = 8'(r_count) + w_inflight;
  assign w_issue_ok = (w_occ < C_DEPTH8);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign w_bypass = w_ret_valid && !w_fifo_nonempty;
`else
  assign w_bypass = 1'b0;
`endif

  // Output selection: bypassed return when the FIFO is empty, else head.
  always_comb begin
    out_valid       = w_bypass || w_fifo_nonempty;
    out_pc          = '0;
    out_instruction = '0;
    if (w_bypass) begin
      out_pc          = w_ret_pc;
      out_instruction = mem_rdata;
    end else if (w_fifo_nonempty) begin
      out_pc          = r_fifo_pc[r_rd_ptr];
      out_instruction = r_fifo_instr[r_rd_ptr];
    end
  end

  assign w_pop      = out_valid && !stall;
  // A consumed bypass never touches the FIFO; a stalled bypass is pushed.
  assign w_fifo_pop = w_pop && !w_bypass;
  assign w_push     = w_ret_valid && !(w_bypass && w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC & C_PC_MASK;
      r_pipe_vld <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        r_pipe_pc[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (flush) begin
      // Redirect beats push, pop and issue; stale in-flight reads are
      // neutralised by dropping their valid bits.
      r_fetch_pc <= flush_pc & C_PC_MASK;
      r_pipe_vld <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_issue_ok) begin
        r_fetch_pc <= r_fetch_pc + 16'd2;
      end
      r_pipe_vld[0] <= w_issue_ok;
      r_pipe_pc[0]  <= r_fetch_pc;
      for (int i = 1; i < MEM_LAT; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_pc[i]  <= r_pipe_pc[i-1];
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_fifo_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      if (w_push && !w_fifo_pop) begin
        r_count <= r_count + C_CNT_ONE;
      end else if (!w_push && w_fifo_pop) begin
        r_count <= r_count - C_CNT_ONE;
      end
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_fifo_pc[r_wr_ptr]    <= w_ret_pc;
      r_fifo_instr[r_wr_ptr] <= mem_rdata;
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (rst) r_count <= C_CNT_DEPTH);

endmodule
`default_nettype wire
